// File: rtl/logic_unit_pipe_pkg.sv
// Shared types and constants for the pipelined logic unit.
package logic_unit_pipe_pkg;

`include "logic_ops_defs.vh"

    // Result flags stored alongside each buffered result.
    typedef struct packed {
        logic zero;
        logic ones;
        logic parity;
    } flags_t;

    // Output buffer depth; occupancy is tracked in two bits (0..2).
    localparam int BUF_DEPTH = 2;

    // Flag value held in an entry after reset: an all-zero result.
    localparam flags_t FLAGS_RESET = '{zero: 1'b1, ones: 1'b0, parity: 1'b0};

    // Occupancy after one cycle of optional push and optional pop.
    function automatic logic [1:0] occ_after(input logic [1:0] occ,
                                             input logic       push,
                                             input logic       pop);
        return occ + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational per-bit logic operation with result flags.
module logic_op_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    // Select the bitwise operation; B is unused for NOTA.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ANDN: result = a & ~b;
            OP_NOTA: result = ~a;
            default: result = '0;
        endcase
    end

    // Reductions also cover WIDTH = 1 (zero = ~r, ones = r, parity = r).
    assign zero   = ~|result;
    assign ones   = &result;
    assign parity = ^result;

endmodule

// File: rtl/logic_ops_defs.vh
// Shared 3-bit operation codes for the bitwise logic unit.
// Included into logic_unit_pipe_pkg so the core and the bench see one definition.
localparam logic [2:0] OP_AND  = 3'b000;
localparam logic [2:0] OP_NAND = 3'b001;
localparam logic [2:0] OP_OR   = 3'b010;
localparam logic [2:0] OP_NOR  = 3'b011;
localparam logic [2:0] OP_XOR  = 3'b100;
localparam logic [2:0] OP_XNOR = 3'b101;
localparam logic [2:0] OP_ANDN = 3'b110;
localparam logic [2:0] OP_NOTA = 3'b111;

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: computes on accept, buffers up to two
// results in FIFO order under valid/ready flow control, counts handshakes.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] done_cnt
);

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_ones;
    logic             core_parity;

    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             head_reg;
    logic             in_ready_reg;
    logic [CNT_W-1:0] done_cnt_reg;

    logic             push;
    logic             pop;
    logic             wr_idx;

    logic [WIDTH-1:0] entry_data  [BUF_DEPTH];
    flags_t           entry_flags [BUF_DEPTH];

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (core_result),
        .zero   (core_zero),
        .ones   (core_ones),
        .parity (core_parity)
    );

    // in_ready is a register, so accept never depends on out_ready this cycle.
    assign push = in_valid & in_ready_reg;
    assign pop  = (occ_reg != 2'd0) & out_ready;

    // With one entry held the free slot is the non-head one; with none the
    // head slot itself is written. Never pushed when full.
    assign wr_idx = head_reg ^ (occ_reg == 2'd1);

    // Next occupancy from the push/pop pair.
    always_comb begin
        occ_next = occ_after(occ_reg, push, pop);
    end

    // Buffer entries: each slot loads the core result when it is the write target.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : gen_entry
            logic [WIDTH-1:0] data_reg;
            flags_t           flags_reg;

            // Slot storage; cleared on reset so out_data reads 0 afterwards.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg  <= '0;
                    flags_reg <= FLAGS_RESET;
                end else if (push && (wr_idx == 1'(gi))) begin
                    data_reg  <= core_result;
                    flags_reg <= '{zero: core_zero, ones: core_ones, parity: core_parity};
                end
            end

            assign entry_data[gi]  = data_reg;
            assign entry_flags[gi] = flags_reg;
        end
    endgenerate

    // Occupancy, head pointer and registered ready; ready is low in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg      <= 2'd0;
            head_reg     <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            occ_reg      <= occ_next;
            head_reg     <= head_reg ^ pop;
            in_ready_reg <= (occ_next < 2'd2);
        end
    end

    // Completed-handshake counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_reg <= '0;
        end else if (pop) begin
            done_cnt_reg <= done_cnt_reg + 1'b1;
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = (occ_reg != 2'd0);
    assign out_data   = entry_data[head_reg];
    assign out_zero   = entry_flags[head_reg].zero;
    assign out_ones   = entry_flags[head_reg].ones;
    assign out_parity = entry_flags[head_reg].parity;
    assign done_cnt   = done_cnt_reg;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the team's fixed 32-bit NAND array.
- Applies one of eight per-bit operations selected per transaction to operands A and B of width WIDTH.
- Registers the result and result flags into a 2-entry output buffer under valid/ready flow control.
- Sits between the operand mux and the result writeback path; used wherever the datapath needs registered logic results with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block can accept this cycle.
- in_op  input  3  operation select, encoding below.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  result.
- out_zero  output  1  result all zeros.
- out_ones  output  1  result all ones.
- out_parity  output  1  XOR-reduction of result.
- done_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Op encoding: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 ANDN (A & ~B), 111 NOTA (~A). B ignored for NOTA.
- Accept = in_valid & in_ready; result and flags computed combinationally from in_op/in_a/in_b on the accept cycle and written into the buffer.
- Output handshake = out_valid & out_ready; pops head entry.
- Buffer: 2 entries, occupancy 0..2, FIFO order.
- out_valid = occupancy != 0; out_data/flags always reflect head entry; hold stable while out_valid & ~out_ready.
- in_ready registered: 1 when next occupancy < 2, i.e. in_ready depends only on state, never combinationally on out_ready.
- Latency: accept at cycle N -> result visible on out_data at cycle N+1 if buffer was empty.
- Throughput: 1 transaction/cycle sustained when out_ready held high.
- Occupancy transitions: push only +1; pop only -1; push and pop together unchanged (occupancy 1: new entry becomes head next cycle).
- Full (occupancy 2): in_ready = 0; pop in that cycle -> occupancy 1, in_ready = 1 next cycle.
- Empty: out_valid = 0; out_data holds last value (don't-care, not checked).
- in_valid with in_ready = 0: no state change; upstream must hold.
- done_cnt increments by 1 on every output handshake; wraps from 2^CNT_W-1 to 0.
- Reset (any cycle, including mid-transfer): occupancy 0, out_valid 0, in_ready 0 during reset and 1 from the first cycle after deassertion, out_data 0, out_zero 1, out_ones 0, out_parity 0, done_cnt 0. In-flight entries discarded.
- WIDTH = 1: out_zero = ~out_data, out_ones = out_data, out_parity = out_data.

Decomposition:
- Shared header logic_ops_defs.vh: 3-bit op code constants (OP_AND … OP_NOTA) for use by the decoder and bench.
- One sub-module: logic_op_core, combinational, parametrised WIDTH; takes op/a/b and produces result, zero, ones, parity. logic_unit_pipe holds the buffer, handshakes and counter.

Test Plan:
- Reset, then single accept op=001, A=0xFFFF0000, B=0xFF00FF00, out_ready=1 -> next cycle out_valid=1, out_data=0x00FFFFFF, zero=0, ones=0, parity=0; done_cnt=1 after handshake.
- All eight ops on A=0xA5A5A5A5, B=0x0F0F0F0F back-to-back, out_ready=1 -> results 05050505, FAFAFAFA, AFAFAFAF, 50505050, AAAAAAAA, 55555555, A0A0A0A0, 5A5A5A5A in order, one per cycle.
- Backpressure: out_ready=0, push 3 transactions -> two accepted, in_ready=0 from third cycle, head stable; raise out_ready -> drained in order, in_ready returns 1 one cycle after first pop.
- Flags: op=100 A=B=0x12345678 -> zero=1; op=011 A=B=0 -> ones=1, out_data=0xFFFFFFFF, parity=0; op=000 A=B=0x00000001 -> parity=1.
- Simultaneous push/pop at occupancy 1 with random ops for 1000 cycles, random out_ready -> results match reference model, no loss/duplication, done_cnt equals handshake count.
- Assert rst with 2 entries buffered -> next cycle out_valid=0, done_cnt=0, in_ready=1 after release; CNT_W=4 run of 17 handshakes -> done_cnt=1 (wrap).
